// File: rtl/mux_alusrc_pkg.sv
// Shared defaults and select encodings for the ALU B-operand source mux.
// The MUX_ALUSRC_STATS_EN macro, when defined, adds per-source selection counters to mux_alusrc_block.
package mux_alusrc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic {
        SEL_REG = 1'b0,
        SEL_IMM = 1'b1
    } alusrc_sel_e;

endpackage

// File: rtl/mux_alusrc_block_sat_counter.sv
// Saturating up-counter with synchronous active-high reset and count enable.
// Latency: count updates on the edge after en; holds at all-ones instead of wrapping.
module sat_counter
    import mux_alusrc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mux_alusrc_block.sv
// ALU B-operand select (register operand or immediate) with a one-cycle registered copy.
// MUX_ALUSRC_STATS_EN adds saturating per-source selection counters; no backpressure.
module mux_alusrc_block
    import mux_alusrc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [DATA_W-1:0] sign_extended,
    input  logic              alusrc,
`ifdef MUX_ALUSRC_STATS_EN
    output logic [CNT_W-1:0]  reg_sel_count,
    output logic [CNT_W-1:0]  imm_sel_count,
`endif
    output logic [DATA_W-1:0] alusrc_result,
    output logic [DATA_W-1:0] alusrc_result_q
);

    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] result_d;
    logic              sel_imm;

    assign sel_imm = (alusrc == SEL_IMM);

    // Purely combinational; reset must not disturb the operand path.
    always_comb begin
        result_d = read_data2;
        if (sel_imm) begin
            result_d = sign_extended;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign alusrc_result   = result_d;
    assign alusrc_result_q = result_q;

`ifdef MUX_ALUSRC_STATS_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_reg_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (!sel_imm),
        .count (reg_sel_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_imm_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (sel_imm),
        .count (imm_sel_count)
    );
`endif

endmodule

// File: tb/tb_mux_alusrc_block.sv
// Directed-vector bench for mux_alusrc_block: driver pushes hand-computed expectations, monitor pops and compares.
// Counter columns are checked only when MUX_ALUSRC_STATS_EN is defined; CNT_W=2 exercises saturation.
module tb_mux_alusrc_block;

    localparam int DW = 32;
    localparam int CW = 2;
    localparam int NV = 16;

    typedef struct {
        logic          rst;
        logic          sel;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [DW-1:0] comb;
        logic [DW-1:0] q;
        logic [CW-1:0] rc;
        logic [CW-1:0] ic;
    } vec_t;

    logic          clk;
    logic          reset;
    logic [DW-1:0] read_data2;
    logic [DW-1:0] sign_extended;
    logic          alusrc;
    logic [DW-1:0] alusrc_result;
    logic [DW-1:0] alusrc_result_q;
`ifdef MUX_ALUSRC_STATS_EN
    logic [CW-1:0] reg_sel_count;
    logic [CW-1:0] imm_sel_count;
`endif

    int   errors = 0;
    int   checks = 0;
    vec_t vecs [NV];
    vec_t sb_q [$];

    mux_alusrc_block #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .read_data2      (read_data2),
        .sign_extended   (sign_extended),
        .alusrc          (alusrc),
`ifdef MUX_ALUSRC_STATS_EN
        .reg_sel_count   (reg_sel_count),
        .imm_sel_count   (imm_sel_count),
`endif
        .alusrc_result   (alusrc_result),
        .alusrc_result_q (alusrc_result_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic sel,
                                input logic [DW-1:0] rd2, input logic [DW-1:0] imm,
                                input logic [DW-1:0] comb, input logic [DW-1:0] q,
                                input logic [CW-1:0] rc, input logic [CW-1:0] ic);
        vec_t v;
        v.rst = rst; v.sel = sel; v.rd2 = rd2; v.imm = imm;
        v.comb = comb; v.q = q; v.rc = rc; v.ic = ic;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected values after the edge that samples each vector (CNT_W=2 saturates at 3).
    initial begin
        vecs[0]  = mk(1, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h0,        2'd0, 2'd0);
        vecs[1]  = mk(1, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h0,        2'd0, 2'd0);
        vecs[2]  = mk(0, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'd1, 2'd0);
        vecs[3]  = mk(0, 1, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2'd1, 2'd1);
        vecs[4]  = mk(0, 0, 32'h12345678, 32'h87654321, 32'h12345678, 32'h12345678, 2'd2, 2'd1);
        vecs[5]  = mk(0, 1, 32'h12345678, 32'h87654321, 32'h87654321, 32'h87654321, 2'd2, 2'd2);
        vecs[6]  = mk(0, 0, 32'h12345678, 32'h87654321, 32'h12345678, 32'h12345678, 2'd3, 2'd2);
        vecs[7]  = mk(0, 1, 32'h12345678, 32'h87654321, 32'h87654321, 32'h87654321, 2'd3, 2'd3);
        vecs[8]  = mk(0, 0, 32'h12345678, 32'h87654321, 32'h12345678, 32'h12345678, 2'd3, 2'd3);
        vecs[9]  = mk(1, 1, 32'h12345678, 32'h87654321, 32'h87654321, 32'h0,        2'd0, 2'd0);
        vecs[10] = mk(0, 1, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2'd0, 2'd1);
        vecs[11] = mk(0, 1, 32'hA5A5A5A5, 32'h00000001, 32'h00000001, 32'h00000001, 2'd0, 2'd2);
        vecs[12] = mk(0, 1, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 2'd3);
        vecs[13] = mk(0, 1, 32'hA5A5A5A5, 32'h80000000, 32'h80000000, 32'h80000000, 2'd0, 2'd3);
        vecs[14] = mk(0, 1, 32'hA5A5A5A5, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'd0, 2'd3);
        vecs[15] = mk(0, 0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 2'd1, 2'd3);
    end

    // Driver: apply one vector per cycle on the falling edge and queue its expectation.
    initial begin
        reset         = 1'b1;
        read_data2    = '0;
        sign_extended = '0;
        alusrc        = 1'b0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset         = vecs[i].rst;
            alusrc        = vecs[i].sel;
            read_data2    = vecs[i].rd2;
            sign_extended = vecs[i].imm;
            sb_q.push_back(vecs[i]);
        end
    end

    // Monitor: before the edge the registered output must still hold the previous value.
    initial begin
        vec_t          e;
        logic [DW-1:0] prev_q;
        prev_q = '0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard_empty: vector %0d got none expected one", i);
            end else begin
                e = sb_q[0];
                chk($sformatf("comb_pre[%0d]", i), alusrc_result, e.comb);
                if (i > 0) chk($sformatf("q_lag[%0d]", i), alusrc_result_q, prev_q);
                @(posedge clk);
                #1;
                e = sb_q.pop_front();
                chk($sformatf("comb_post[%0d]", i), alusrc_result, e.comb);
                chk($sformatf("q[%0d]", i), alusrc_result_q, e.q);
`ifdef MUX_ALUSRC_STATS_EN
                chk($sformatf("reg_cnt[%0d]", i), {{(DW-CW){1'b0}}, reg_sel_count}, {{(DW-CW){1'b0}}, e.rc});
                chk($sformatf("imm_cnt[%0d]", i), {{(DW-CW){1'b0}}, imm_sel_count}, {{(DW-CW){1'b0}}, e.ic});
`endif
                prev_q = e.q;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux_alusrc_block.md
MUX_ALUSRC_BLOCK -- requirements
Module: mux_alusrc

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set operand and result width in bits.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of each selection counter (used only when MUX_ALUSRC_STATS_EN is defined).
REQ-003 The block SHALL have one clock, clk; reset, named reset, SHALL be synchronous and active-high.
REQ-004 Port clk, input, 1 bit: rising-edge clock for all registered state.
REQ-005 Port reset, input, 1 bit: synchronous active-high reset.
REQ-006 Port read_data2, input, DATA_W bits: register-file second read operand.
REQ-007 Port sign_extended, input, DATA_W bits: sign-extended immediate operand.
REQ-008 Port alusrc, input, 1 bit: ALU source select; 0 = read_data2, 1 = sign_extended.
REQ-009 Port alusrc_result, output, DATA_W bits: selected ALU B operand, combinational.
REQ-010 Port alusrc_result_q, output, DATA_W bits: alusrc_result registered on clk.
REQ-011 Ports reg_sel_count and imm_sel_count, output, CNT_W bits each, present only with MUX_ALUSRC_STATS_EN: cycles in which each source was selected.

Function
REQ-012 alusrc_result SHALL equal read_data2 when alusrc = 0 and sign_extended when alusrc = 1, with zero-cycle combinational latency.
REQ-013 alusrc_result SHALL follow any input change in the same delta/cycle, with no dependence on clk or reset.
REQ-014 All DATA_W bits SHALL pass unmodified; no extension, truncation or arithmetic.
REQ-015 alusrc_result_q SHALL load alusrc_result on every rising clk edge when reset is low, giving exactly one cycle of latency.
REQ-016 With stats enabled, each rising edge with reset low SHALL increment imm_sel_count when alusrc = 1, else reg_sel_count; exactly one counter increments per cycle.
REQ-017 Each counter SHALL saturate at all-ones and hold; it SHALL NOT wrap.
REQ-018 If alusrc toggles every cycle, the registered output and counters SHALL track each cycle's selection with no missed or merged samples.

Reset
REQ-019 With reset high at a rising edge, alusrc_result_q SHALL become 0 and both counters SHALL become 0.
REQ-020 Reset SHALL NOT affect alusrc_result; the combinational path stays valid during reset.
REQ-021 Reset asserted mid-operation SHALL take priority over loading and counting on that edge; normal operation SHALL resume on the first edge with reset low.

Configuration
REQ-022 Macro MUX_ALUSRC_STATS_EN SHALL include the selection counters and their ports when defined; when undefined, the counters and ports SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-023 Package mux_alusrc_pkg SHALL hold DATA_W default, select encodings SEL_REG = 0 and SEL_IMM = 1, and the counter-width default.
REQ-024 One sub-module, sat_counter (CNT_W-wide, synchronous reset, enable, saturating), SHALL be instantiated twice for the statistics.

Verification
REQ-025 read_data2=A5A5A5A5, sign_extended=DEADBEEF, alusrc=0 -> alusrc_result=A5A5A5A5 immediately; alusrc_result_q=A5A5A5A5 after one edge.
REQ-026 Same data, alusrc=1 -> alusrc_result=DEADBEEF; reg_sel_count and imm_sel_count each increment on the matching edges.
REQ-027 read_data2=12345678, sign_extended=87654321, alusrc=0 then 1 -> alusrc_result=12345678 then 87654321, with alusrc_q lagging by one cycle.
REQ-028 reset high for one edge mid-stream -> alusrc_result_q=0 and counters=0, while alusrc_result still equals the selected input.
REQ-029 CNT_W=2, alusrc held at 1 for 5 edges -> imm_sel_count=3 and stays at 3.
REQ-030 Build without MUX_ALUSRC_STATS_EN -> compiles without counter ports; REQ-025 to REQ-028 results unchanged.
